// File: rtl/rgb_lcd_timing_if.sv
// rtl/rgb_lcd_timing_if.sv - pixel-source and LCD-pin bundle for rgb_lcd_timing
interface rgb_lcd_timing_if;
  logic        en;
  logic [15:0] pixel_data;
  logic        pixel_req;
  logic [10:0] pix_x;
  logic [10:0] pix_y;
  logic        lcd_hs;
  logic        lcd_vs;
  logic        lcd_de;
  logic [15:0] lcd_rgb;
  logic        frame_start;

  modport master (
    input  en, pixel_data,
    output pixel_req, pix_x, pix_y, lcd_hs, lcd_vs, lcd_de, lcd_rgb, frame_start
  );

  modport slave (
    output en, pixel_data,
    input  pixel_req, pix_x, pix_y, lcd_hs, lcd_vs, lcd_de, lcd_rgb, frame_start
  );
endinterface

// File: rtl/rgb_lcd_timing.sv
// rtl/rgb_lcd_timing.sv - HS/VS/DE timing generator for an RGB565 LCD
// Define RGB_LCD_COLORBAR_EN to replace pixel_data with an internal 8-bar pattern.
module rgb_lcd_timing #(
  parameter int   H_ACTIVE = 800,
  parameter int   H_FP     = 40,
  parameter int   H_SYNC   = 128,
  parameter int   H_BP     = 88,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 13,
  parameter int   V_SYNC   = 3,
  parameter int   V_BP     = 29,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0
) (
  input logic              clk,
  input logic              rst_n,
  rgb_lcd_timing_if.master bus
);

  localparam logic [10:0] H_LAST  = 11'(H_SYNC + H_BP + H_ACTIVE + H_FP - 1);
  localparam logic [10:0] V_LAST  = 11'(V_SYNC + V_BP + V_ACTIVE + V_FP - 1);
  localparam logic [10:0] H_START = 11'(H_SYNC + H_BP);
  localparam logic [10:0] H_END   = 11'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [10:0] V_START = 11'(V_SYNC + V_BP);
  localparam logic [10:0] V_END   = 11'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [10:0] H_SW    = 11'(H_SYNC);
  localparam logic [10:0] V_SW    = 11'(V_SYNC);

  logic [10:0] h_cnt_q, h_cnt_d;
  logic [10:0] v_cnt_q, v_cnt_d;
  logic        lcd_hs_q, lcd_hs_d;
  logic        lcd_vs_q, lcd_vs_d;
  logic        lcd_de_q, lcd_de_d;
  logic [15:0] lcd_rgb_q, lcd_rgb_d;
  logic        frame_start_q, frame_start_d;
  logic        active;
  logic        pixel_req;
  logic [15:0] pix_src;

  always_comb begin
    h_cnt_d = '0;
    v_cnt_d = '0;
    if (bus.en) begin
      if (h_cnt_q == H_LAST) begin
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 11'd1;
      end else begin
        h_cnt_d = h_cnt_q + 11'd1;
        v_cnt_d = v_cnt_q;
      end
    end
  end

  always_comb begin
    active = (h_cnt_q >= H_START) && (h_cnt_q < H_END) &&
             (v_cnt_q >= V_START) && (v_cnt_q < V_END);
    pixel_req     = active && bus.en;
    lcd_hs_d      = ((h_cnt_q < H_SW) && bus.en) ? HS_POL : ~HS_POL;
    lcd_vs_d      = ((v_cnt_q < V_SW) && bus.en) ? VS_POL : ~VS_POL;
    lcd_de_d      = pixel_req;
    lcd_rgb_d     = pixel_req ? pix_src : 16'h0000;
    frame_start_d = (h_cnt_q == 11'd0) && (v_cnt_q == 11'd0) && bus.en;
  end

`ifdef RGB_LCD_COLORBAR_EN
  localparam logic [10:0] BAR_LAST = 11'(H_ACTIVE / 8 - 1);

  logic [10:0] bar_cnt_q, bar_cnt_d;
  logic [2:0]  bar_idx_q, bar_idx_d;

  // Bar state always describes the pixel currently requested; cleared between lines.
  always_comb begin
    bar_cnt_d = '0;
    bar_idx_d = '0;
    if (pixel_req) begin
      if (bar_cnt_q == BAR_LAST) begin
        bar_idx_d = bar_idx_q + 3'd1;
      end else begin
        bar_cnt_d = bar_cnt_q + 11'd1;
        bar_idx_d = bar_idx_q;
      end
    end
  end

  always_comb begin
    pix_src = 16'h0000;
    case (bar_idx_q)
      3'd0: pix_src = 16'hFFFF;
      3'd1: pix_src = 16'hFFE0;
      3'd2: pix_src = 16'h07FF;
      3'd3: pix_src = 16'h07E0;
      3'd4: pix_src = 16'hF81F;
      3'd5: pix_src = 16'hF800;
      3'd6: pix_src = 16'h001F;
      default: pix_src = 16'h0000;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bar_cnt_q <= '0;
      bar_idx_q <= '0;
    end else begin
      bar_cnt_q <= bar_cnt_d;
      bar_idx_q <= bar_idx_d;
    end
  end
`else
  assign pix_src = bus.pixel_data;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      lcd_hs_q      <= ~HS_POL;
      lcd_vs_q      <= ~VS_POL;
      lcd_de_q      <= 1'b0;
      lcd_rgb_q     <= 16'h0000;
      frame_start_q <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      lcd_hs_q      <= lcd_hs_d;
      lcd_vs_q      <= lcd_vs_d;
      lcd_de_q      <= lcd_de_d;
      lcd_rgb_q     <= lcd_rgb_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.pixel_req   = pixel_req;
  assign bus.pix_x       = active ? h_cnt_q - H_START : 11'd0;
  assign bus.pix_y       = active ? v_cnt_q - V_START : 11'd0;
  assign bus.lcd_hs      = lcd_hs_q;
  assign bus.lcd_vs      = lcd_vs_q;
  assign bus.lcd_de      = lcd_de_q;
  assign bus.lcd_rgb     = lcd_rgb_q;
  assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_rgb_lcd_timing.sv
// tb/tb_rgb_lcd_timing.sv - directed-vector bench for rgb_lcd_timing on a shrunken 25x9 raster
module tb_rgb_lcd_timing;

  // Raster: H 3+4+16+2 = 25, V 2+2+4+1 = 9, frame = 225 cycles.
  localparam int TB_HS = 3, TB_HB = 4, TB_HA = 16, TB_HF = 2;
  localparam int TB_VS = 2, TB_VB = 2, TB_VA = 4, TB_VF = 1;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  int   n = 0;

  rgb_lcd_timing_if bus ();

  rgb_lcd_timing #(
    .H_ACTIVE(TB_HA), .H_FP(TB_HF), .H_SYNC(TB_HS), .H_BP(TB_HB),
    .V_ACTIVE(TB_VA), .V_FP(TB_VF), .V_SYNC(TB_VS), .V_BP(TB_VB),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

`ifdef RGB_LCD_COLORBAR_EN
  assign bus.pixel_data = 16'hA5A5;
`else
  assign bus.pixel_data = {5'd0, bus.pix_x};
`endif

  typedef struct {
    int   n;
    logic hs, vs, de;
    int   x;
    logic fs, req;
    int   px, py;
  } vec_t;

  vec_t vecs[18];

  function automatic logic [15:0] exp_pix(int x);
`ifdef RGB_LCD_COLORBAR_EN
    case (x / (TB_HA / 8))
      0: return 16'hFFFF;
      1: return 16'hFFE0;
      2: return 16'h07FF;
      3: return 16'h07E0;
      4: return 16'hF81F;
      5: return 16'hF800;
      6: return 16'h001F;
      default: return 16'h0000;
    endcase
`else
    return 16'(x);
`endif
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    n++;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, hs_low, vs_low, de_hi, de_rise, fs_cnt;
    logic de_prev;

    // n = edges since reset release; outputs reflect counter n-1, comb signals counter n.
    vecs[0]  = '{0,   1'b1, 1'b1, 1'b0, 0,  1'b0, 1'b0, 0,  0};
    vecs[1]  = '{1,   1'b0, 1'b0, 1'b0, 0,  1'b1, 1'b0, 0,  0};
    vecs[2]  = '{2,   1'b0, 1'b0, 1'b0, 0,  1'b0, 1'b0, 0,  0};
    vecs[3]  = '{3,   1'b0, 1'b0, 1'b0, 0,  1'b0, 1'b0, 0,  0};
    vecs[4]  = '{4,   1'b1, 1'b0, 1'b0, 0,  1'b0, 1'b0, 0,  0};
    vecs[5]  = '{26,  1'b0, 1'b0, 1'b0, 0,  1'b0, 1'b0, 0,  0};
    vecs[6]  = '{51,  1'b0, 1'b1, 1'b0, 0,  1'b0, 1'b0, 0,  0};
    vecs[7]  = '{107, 1'b1, 1'b1, 1'b0, 0,  1'b0, 1'b1, 0,  0};
    vecs[8]  = '{108, 1'b1, 1'b1, 1'b1, 0,  1'b0, 1'b1, 1,  0};
    vecs[9]  = '{109, 1'b1, 1'b1, 1'b1, 1,  1'b0, 1'b1, 2,  0};
    vecs[10] = '{111, 1'b1, 1'b1, 1'b1, 3,  1'b0, 1'b1, 4,  0};
    vecs[11] = '{122, 1'b1, 1'b1, 1'b1, 14, 1'b0, 1'b1, 15, 0};
    vecs[12] = '{123, 1'b1, 1'b1, 1'b1, 15, 1'b0, 1'b0, 0,  0};
    vecs[13] = '{124, 1'b1, 1'b1, 1'b0, 0,  1'b0, 1'b0, 0,  0};
    vecs[14] = '{197, 1'b1, 1'b1, 1'b1, 14, 1'b0, 1'b1, 15, 3};
    vecs[15] = '{198, 1'b1, 1'b1, 1'b1, 15, 1'b0, 1'b0, 0,  0};
    vecs[16] = '{208, 1'b1, 1'b1, 1'b0, 0,  1'b0, 1'b0, 0,  0};
    vecs[17] = '{226, 1'b0, 1'b0, 1'b0, 0,  1'b1, 1'b0, 0,  0};

    rst_n  = 1'b0;
    bus.en = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n = 0;

    foreach (vecs[i]) begin
      while (n < vecs[i].n) step();
      #1;
      check($sformatf("v%0d_hs", vecs[i].n), 32'(bus.lcd_hs), 32'(vecs[i].hs));
      check($sformatf("v%0d_vs", vecs[i].n), 32'(bus.lcd_vs), 32'(vecs[i].vs));
      check($sformatf("v%0d_de", vecs[i].n), 32'(bus.lcd_de), 32'(vecs[i].de));
      check($sformatf("v%0d_rgb", vecs[i].n), 32'(bus.lcd_rgb),
            vecs[i].de ? 32'(exp_pix(vecs[i].x)) : 32'h0);
      check($sformatf("v%0d_fs", vecs[i].n), 32'(bus.frame_start), 32'(vecs[i].fs));
      check($sformatf("v%0d_req", vecs[i].n), 32'(bus.pixel_req), 32'(vecs[i].req));
      check($sformatf("v%0d_px", vecs[i].n), 32'(bus.pix_x), 32'(vecs[i].px));
      check($sformatf("v%0d_py", vecs[i].n), 32'(bus.pix_y), 32'(vecs[i].py));
    end

    // One whole frame starting at a frame_start sample.
    cnt = 0;
    while (!bus.frame_start && cnt < 300) begin step(); cnt++; end
    check("frame_sync_found", 32'(bus.frame_start), 32'h1);
    hs_low = 0; vs_low = 0; de_hi = 0; de_rise = 0; fs_cnt = 0; de_prev = 1'b0;
    for (int k = 0; k < 225; k++) begin
      if (!bus.lcd_hs) hs_low++;
      if (!bus.lcd_vs) vs_low++;
      if (bus.lcd_de) de_hi++;
      if (bus.lcd_de && !de_prev) de_rise++;
      if (bus.frame_start) fs_cnt++;
      de_prev = bus.lcd_de;
      step();
    end
    check("frame_hs_low", 32'(hs_low), 32'(TB_HS * 9));
    check("frame_vs_low", 32'(vs_low), 32'(TB_VS * 25));
    check("frame_de_cycles", 32'(de_hi), 32'(TB_HA * TB_VA));
    check("frame_de_lines", 32'(de_rise), 32'(TB_VA));
    check("frame_fs_count", 32'(fs_cnt), 32'h1);
    check("frame_period", 32'(bus.frame_start), 32'h1);

    // Enable drop in the middle of an active line.
    cnt = 0;
    while (!bus.lcd_de && cnt < 300) begin step(); cnt++; end
    repeat (5) step();
    check("endrop_de_before", 32'(bus.lcd_de), 32'h1);
    bus.en = 1'b0;
    #1;
    check("endrop_req", 32'(bus.pixel_req), 32'h0);
    step();
    check("endrop_de", 32'(bus.lcd_de), 32'h0);
    check("endrop_hs", 32'(bus.lcd_hs), 32'h1);
    check("endrop_vs", 32'(bus.lcd_vs), 32'h1);
    check("endrop_rgb", 32'(bus.lcd_rgb), 32'h0);
    repeat (3) step();
    check("idle_fs", 32'(bus.frame_start), 32'h0);
    check("idle_hs", 32'(bus.lcd_hs), 32'h1);
    bus.en = 1'b1;
    step();
    check("enrise_fs", 32'(bus.frame_start), 32'h1);
    cnt = 0;
    while (!bus.lcd_de && cnt < 500) begin step(); cnt++; end
    check("enrise_first_de", 32'(cnt), 32'((TB_VS + TB_VB) * 25 + TB_HS + TB_HB));

    // Asynchronous reset while DE is high.
    check("rst_de_before", 32'(bus.lcd_de), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_hs", 32'(bus.lcd_hs), 32'h1);
    check("rst_vs", 32'(bus.lcd_vs), 32'h1);
    check("rst_de", 32'(bus.lcd_de), 32'h0);
    check("rst_rgb", 32'(bus.lcd_rgb), 32'h0);
    check("rst_fs", 32'(bus.frame_start), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("rst_release_fs", 32'(bus.frame_start), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
